// File: rtl/snake_pkg.sv
// snake_pkg: shared grid geometry, cell coordinate types and apple spawner states
package snake_pkg;

    localparam int GRID_W = 40;
    localparam int GRID_H = 30;
    localparam int CELL   = 16;

    typedef logic [5:0] col_t;
    typedef logic [4:0] row_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SAMPLE,
        S_QUERY,
        S_SCAN,
        S_PLACE
    } spawn_state_t;

endpackage

// File: rtl/apple_cell_fold.sv
// apple_cell_fold: folds a 9-bit random word into a (col,row) grid cell
module apple_cell_fold
    import snake_pkg::*;
#(
    parameter int GW = GRID_W,
    parameter int GH = GRID_H
) (
    input  logic [8:0] rand_word,
    output col_t       col,
    output row_t       row
);

    localparam col_t GW_C = col_t'(GW);
    localparam row_t GH_R = row_t'(GH);

    // one conditional subtract per axis; a full-width grid casts to 0 and leaves the raw value
    always_comb begin
        col = (rand_word[5:0] >= GW_C) ? rand_word[5:0] - GW_C : rand_word[5:0];
        row = (rand_word[8:4] >= GH_R) ? rand_word[8:4] - GH_R : rand_word[8:4];
    end

endmodule

// File: rtl/apple_spawner.sv
// apple_spawner: picks a free grid cell for the next apple through occupancy queries.
// Build option: define APPLE_SCAN_FALLBACK_EN to scan linearly after MAX_TRIES random collisions.
module apple_spawner #(
    parameter int GRID_W    = snake_pkg::GRID_W,
    parameter int GRID_H    = snake_pkg::GRID_H,
    parameter int CELL      = snake_pkg::CELL,
    parameter int MAX_TRIES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [8:0] rand_word,
    input  logic       spawn_req,
    output logic       occ_query,
    output logic [5:0] occ_col,
    output logic [4:0] occ_row,
    input  logic       occ_ack,
    input  logic       occ_hit,
    output logic       busy,
    output logic       apple_valid,
    output logic       apple_new,
    output logic       spawn_fail,
    output logic [9:0] x,
    output logic [9:0] y
);
    import snake_pkg::*;

    localparam int            TW       = $clog2(MAX_TRIES + 1);
    localparam logic [TW-1:0] TRY_LAST = TW'(MAX_TRIES - 1);
    localparam logic [9:0]    CELL_PX  = 10'(CELL);

    spawn_state_t  state;
    logic [TW-1:0] tries;
    col_t          fold_col;
    row_t          fold_row;
    logic [9:0]    px_x;
    logic [9:0]    px_y;

    apple_cell_fold #(
        .GW(GRID_W),
        .GH(GRID_H)
    ) u_fold (
        .rand_word(rand_word),
        .col(fold_col),
        .row(fold_row)
    );

    // pixel position of the cell currently under query
    always_comb begin
        px_x = 10'(occ_col) * CELL_PX;
        px_y = 10'(occ_row) * CELL_PX;
    end

`ifdef APPLE_SCAN_FALLBACK_EN
    localparam col_t        LAST_COL  = col_t'(GRID_W - 1);
    localparam row_t        LAST_ROW  = row_t'(GRID_H - 1);
    localparam logic [11:0] SCAN_LAST = 12'(GRID_W * GRID_H - 1);

    logic [11:0] scan_n;
    col_t        next_col;
    row_t        next_row;

    // raster-order successor of the current cell, wrapping at the grid edges
    always_comb begin
        next_col = (occ_col >= LAST_COL) ? '0 : occ_col + 6'd1;
        next_row = (occ_col < LAST_COL) ? occ_row : (occ_row >= LAST_ROW) ? '0 : occ_row + 5'd1;
    end
`endif

    // sequencer: sample, query, optional scan, then place or fail; every output is registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            tries       <= '0;
            occ_query   <= 1'b0;
            occ_col     <= '0;
            occ_row     <= '0;
            busy        <= 1'b0;
            apple_valid <= 1'b0;
            apple_new   <= 1'b0;
            spawn_fail  <= 1'b0;
            x           <= '0;
            y           <= '0;
`ifdef APPLE_SCAN_FALLBACK_EN
            scan_n      <= '0;
`endif
        end else begin
            apple_new  <= 1'b0;
            spawn_fail <= 1'b0;
            case (state)
                S_IDLE: if (spawn_req) begin
                    apple_valid <= 1'b0;
                    tries       <= '0;
                    busy        <= 1'b1;
                    state       <= S_SAMPLE;
                end
                S_SAMPLE: begin
                    occ_col   <= fold_col;
                    occ_row   <= fold_row;
                    occ_query <= 1'b1;
                    state     <= S_QUERY;
                end
                S_QUERY: if (occ_ack) begin
                    occ_query <= 1'b0;
                    if (!occ_hit) begin
                        x           <= px_x;
                        y           <= px_y;
                        apple_valid <= 1'b1;
                        apple_new   <= 1'b1;
                        state       <= S_PLACE;
                    end else begin
                        tries <= tries + TW'(1);
                        if (tries != TRY_LAST) begin
                            state <= S_SAMPLE;
                        end else begin
`ifdef APPLE_SCAN_FALLBACK_EN
                            scan_n <= '0;
                            state  <= S_SCAN;
`else
                            spawn_fail <= 1'b1;
                            busy       <= 1'b0;
                            state      <= S_IDLE;
`endif
                        end
                    end
                end
`ifdef APPLE_SCAN_FALLBACK_EN
                S_SCAN: if (!occ_query) begin
                    occ_col   <= next_col;
                    occ_row   <= next_row;
                    occ_query <= 1'b1;
                end else if (occ_ack) begin
                    occ_query <= 1'b0;
                    if (!occ_hit) begin
                        x           <= px_x;
                        y           <= px_y;
                        apple_valid <= 1'b1;
                        apple_new   <= 1'b1;
                        state       <= S_PLACE;
                    end else if (scan_n == SCAN_LAST) begin
                        spawn_fail <= 1'b1;
                        busy       <= 1'b0;
                        state      <= S_IDLE;
                    end else begin
                        scan_n <= scan_n + 12'd1;
                    end
                end
`endif
                S_PLACE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy      <= 1'b0;
                    occ_query <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apple_spawner.sv
// tb_apple_spawner: randomized bench for apple_spawner against a transaction-level model
module tb_apple_spawner;

    localparam int GW   = 40;
    localparam int GH   = 30;
    localparam int CELL = 16;
    localparam int MT   = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       spawn_req = 1'b0;
    logic [8:0] rand_word = '0;
    logic       occ_ack = 1'b0;
    logic       occ_hit = 1'b0;
    logic       occ_query, busy, apple_valid, apple_new, spawn_fail;
    logic [5:0] occ_col;
    logic [4:0] occ_row;
    logic [9:0] x, y;

    int checks = 0;
    int errors = 0;

    // stimulus knobs
    logic       rand_rand = 1'b0;
    logic [8:0] rand_fix = '0;
    logic       manual = 1'b0, man_ack = 1'b0, man_hit = 1'b0, spur_en = 1'b0;
    int         hit_until = 0, hit_pct = 0, max_wait = 0, q_idx = 0, q_mark = 0, wcnt = 0;

    // reference model state
    int   exp_col = 0, exp_row = 0, exp_x = 0, exp_y = 0;
    logic exp_query = 1'b0, exp_busy = 1'b0, exp_valid = 1'b0, exp_new = 1'b0, exp_fail = 1'b0;
    logic ab = 1'b0;

    apple_spawner dut (
        .clk(clk),
        .rst_n(rst_n),
        .rand_word(rand_word),
        .spawn_req(spawn_req),
        .occ_query(occ_query),
        .occ_col(occ_col),
        .occ_row(occ_row),
        .occ_ack(occ_ack),
        .occ_hit(occ_hit),
        .busy(busy),
        .apple_valid(apple_valid),
        .apple_new(apple_new),
        .spawn_fail(spawn_fail),
        .x(x),
        .y(y)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // random word source
    always begin
        @(posedge clk);
        #1;
        rand_word = rand_rand ? 9'($urandom) : rand_fix;
    end

    // occupancy responder: random wait, forced hits for the first hit_until queries, else random
    always begin
        @(posedge clk);
        #1;
        if (manual) begin
            occ_ack = man_ack;
            occ_hit = man_hit;
        end else if (occ_query) begin
            if (wcnt == 0) begin
                occ_ack = 1'b1;
                occ_hit = ((q_idx - q_mark) < hit_until) || ($urandom_range(0, 99) < hit_pct);
                q_idx++;
                wcnt = $urandom_range(0, max_wait);
            end else begin
                wcnt--;
                occ_ack = 1'b0;
                occ_hit = 1'($urandom_range(0, 1));
            end
        end else begin
            occ_ack = spur_en && ($urandom_range(0, 7) == 0);
            occ_hit = 1'($urandom_range(0, 1));
        end
    end

    // model timeline step: one clock edge, or the asynchronous reset
    task automatic tick();
        @(posedge clk or negedge rst_n);
        exp_new  = 1'b0;
        exp_fail = 1'b0;
        if (!rst_n) begin
            ab        = 1'b1;
            exp_query = 1'b0;
            exp_busy  = 1'b0;
            exp_valid = 1'b0;
            exp_x     = 0;
            exp_y     = 0;
            exp_col   = 0;
            exp_row   = 0;
        end
    endtask

    task automatic wait_ack();
        do begin
            tick();
            if (ab) return;
        end while (occ_ack !== 1'b1);
    endtask

    task automatic model_place();
        exp_x     = exp_col * CELL;
        exp_y     = exp_row * CELL;
        exp_valid = 1'b1;
        exp_new   = 1'b1;
        tick();
        if (ab) return;
        exp_busy = 1'b0;
    endtask

    task automatic model_txn();
        int tries;
        int c;
        int r;
        exp_busy  = 1'b1;
        exp_valid = 1'b0;
        tries     = 0;
        while (tries < MT) begin
            tick();
            if (ab) return;
            c = int'(rand_word[5:0]);
            r = int'(rand_word[8:4]);
            exp_col   = (c >= GW) ? c - GW : c;
            exp_row   = (r >= GH) ? r - GH : r;
            exp_query = 1'b1;
            wait_ack();
            if (ab) return;
            exp_query = 1'b0;
            if (!occ_hit) begin
                model_place();
                return;
            end
            tries++;
        end
`ifdef APPLE_SCAN_FALLBACK_EN
        for (int n = 0; n < GW * GH; n++) begin
            tick();
            if (ab) return;
            exp_col = (exp_col + 1) % GW;
            if (exp_col == 0) exp_row = (exp_row + 1) % GH;
            exp_query = 1'b1;
            wait_ack();
            if (ab) return;
            exp_query = 1'b0;
            if (!occ_hit) begin
                model_place();
                return;
            end
        end
`endif
        exp_fail = 1'b1;
        exp_busy = 1'b0;
    endtask

    // model driver: idle until an accepted request, then play out one transaction
    initial begin
        forever begin
            tick();
            if (!ab && rst_n && spawn_req) model_txn();
            ab = 1'b0;
        end
    end

    // per-cycle comparison of every output against the model
    always @(negedge clk) begin
        chk("occ_query", int'(occ_query), int'(exp_query));
        chk("occ_col", int'(occ_col), exp_col);
        chk("occ_row", int'(occ_row), exp_row);
        chk("busy", int'(busy), int'(exp_busy));
        chk("apple_valid", int'(apple_valid), int'(exp_valid));
        chk("apple_new", int'(apple_new), int'(exp_new));
        chk("spawn_fail", int'(spawn_fail), int'(exp_fail));
        chk("x", int'(x), exp_x);
        chk("y", int'(y), exp_y);
    end

    // directed spawn: lat counts cycles from the request until apple_new or spawn_fail
    task automatic spawn(input logic [8:0] r, input int hu, output int lat);
        rand_fix  = r;
        hit_until = hu;
        repeat (2) cyc();
        q_mark    = q_idx;
        spawn_req = 1'b1;
        cyc();
        spawn_req = 1'b0;
        lat = 1;
        while (!apple_new && !spawn_fail && lat < 300) begin
            cyc();
            lat++;
        end
        if (lat >= 300) chk("spawn_done", 0, 1);
    endtask

    initial begin
        int lat;
        int n;
        repeat (2) cyc();
        chk("rst_query", int'(occ_query), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_x", int'(x), 0);
        chk("rst_y", int'(y), 0);
        chk("rst_valid", int'(apple_valid), 0);
        rst_n = 1'b1;
        cyc();

        spawn(9'h000, 0, lat);
        chk("lat_min", lat, 3);
        chk("x_000", int'(x), 0);
        chk("y_000", int'(y), 0);
        chk("valid_000", int'(apple_valid), 1);

        spawn(9'h1FF, 0, lat);
        chk("x_1ff", int'(x), 368);
        chk("y_1ff", int'(y), 16);

        spawn(9'h02A, 0, lat);
        chk("x_02a", int'(x), 32);
        chk("y_02a", int'(y), 32);

        spawn(9'h02A, 1, lat);
        chk("lat_retry", lat, 5);

        rand_fix  = 9'h1FF;
        hit_until = 1;
        repeat (2) cyc();
        q_mark    = q_idx;
        spawn_req = 1'b1;
        cyc();
        spawn_req = 1'b0;
        cyc();
        spawn_req = 1'b1;
        cyc();
        spawn_req = 1'b0;
        n = 0;
        repeat (12) begin
            cyc();
            n += int'(apple_new);
        end
        chk("one_apple", n, 1);
        chk("x_busy", int'(x), 368);

        spawn(9'h1DF, 16, lat);
`ifdef APPLE_SCAN_FALLBACK_EN
        chk("scan_lat", lat, 35);
        chk("scan_new", int'(apple_new), 1);
        chk("scan_x", int'(x), 0);
        chk("scan_y", int'(y), 0);
        chk("scan_valid", int'(apple_valid), 1);
`else
        chk("fail_lat", lat, 17);
        chk("fail_pulse", int'(spawn_fail), 1);
        chk("fail_valid", int'(apple_valid), 0);
        chk("fail_busy", int'(busy), 0);
        chk("fail_x_hold", int'(x), 368);
`endif

        manual    = 1'b1;
        man_ack   = 1'b0;
        rand_fix  = 9'h02A;
        hit_until = 0;
        repeat (2) cyc();
        spawn_req = 1'b1;
        cyc();
        spawn_req = 1'b0;
        cyc();
        chk("rq_query_up", int'(occ_query), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rq_query_down", int'(occ_query), 0);
        chk("rq_busy", int'(busy), 0);
        chk("rq_x", int'(x), 0);
        chk("rq_y", int'(y), 0);
        cyc();
        rst_n   = 1'b1;
        man_ack = 1'b1;
        man_hit = 1'b0;
        n = 0;
        repeat (4) begin
            cyc();
            n += int'(apple_new);
        end
        chk("rq_no_new", n, 0);
        man_ack = 1'b0;
        manual  = 1'b0;
        cyc();

        rand_rand = 1'b1;
        spur_en   = 1'b1;
        max_wait  = 3;
        for (int i = 0; i < 4000; i++) begin
            hit_pct   = ((i / 500) % 2 == 1) ? 92 : 35;
            spawn_req = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 499) == 0) begin
                spawn_req = 1'b0;
                #2 rst_n = 1'b0;
                cyc();
                rst_n = 1'b1;
            end else begin
                cyc();
            end
        end
        spawn_req = 1'b0;
        repeat (3) cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
